// File: rtl/alu_mbyte_seq_if.sv
// Request/response bundle for the multi-byte add/sub sequencer.
// The master side issues operands and takes results; the slave side is the sequencer.
interface alu_mbyte_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Cout;
  logic         Ovf;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, Result, Cout, Ovf
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, Result, Cout, Ovf
  );
endinterface

// File: rtl/alu_mbyte_seq.sv
// NBYTES-wide add/sub on a shared external 8-bit adder, one byte per cycle, LSB first.
// Result valid NBYTES cycles after accept; result held in DONE until out_ready, no accept meanwhile.
module alu_mbyte_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_mbyte_seq_if.slave      bus,
  output logic [7:0]          add_A,
  output logic [7:0]          add_B,
  output logic                add_Cin,
  input  logic [7:0]          add_Sum,
  input  logic                add_Cout
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    bx_r;
  logic            carry;
  logic [IDXW-1:0] idx;

  // Adder inputs are forced to zero outside RUN so a shared adder sees no activity.
  always_comb begin
    add_A   = '0;
    add_B   = '0;
    add_Cin = 1'b0;
    if (state == RUN) begin
      add_A   = a_r[8*idx +: 8];
      add_B   = bx_r[8*idx +: 8];
      add_Cin = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.Result    <= '0;
      bus.Cout      <= 1'b0;
      bus.Ovf       <= 1'b0;
      a_r           <= '0;
      bx_r          <= '0;
      carry         <= 1'b0;
      idx           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            // Subtract is A + ~B + 1: invert B once here and seed the carry with op.
            a_r          <= bus.A;
            bx_r         <= bus.op ? ~bus.B : bus.B;
            carry        <= bus.op;
            idx          <= '0;
            bus.Result   <= '0;
            bus.in_ready <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          bus.Result[8*idx +: 8] <= add_Sum;
          carry                  <= add_Cout;
          if (idx == LAST) begin
            bus.Cout      <= add_Cout;
            bus.Ovf       <= (a_r[W-1] == bx_r[W-1]) && (add_Sum[7] != a_r[W-1]);
            idx           <= '0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
